mod_exp_ctrl: RTL and testbench

- Sequencer for the Montgomery product unit: performs left-to-right square-and-multiply modular exponentiation by issuing OPXX (square), OPXM (multiply) and OPX1 (exit Montgomery domain) operations.
- Sits between the host/top level and mon_prod; drives its start, op_code and mp_count, and watches its stop.
- Host preloads x_bar = R mod m at addresses 0/1 and M_bar at 2/3 before starting. The final result is left at addresses 0/1.

---
 rtl/mp_pkg.sv | 43 ++++
 rtl/mp_issue.sv | 47 ++++
 rtl/mod_exp_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the Montgomery product unit and its exponentiation sequencer.
// Op codes are also used by mon_prod.
package mp_pkg;

  localparam int OPC_W    = 2;
  localparam int BITLEN   = 1024;
  localparam int IDX_W_DEF = $clog2(BITLEN) + 1;
  localparam int MP_CNT_W = 10;

  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OPXX = opc_t'(0);
  localparam opc_t OPXM = opc_t'(1);
  localparam opc_t OPX1 = opc_t'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NEXT  = 3'd1,
    S_FINAL = 3'd2,
    S_OP    = 3'd3,
    S_DONE  = 3'd4
`ifdef LEADING_ZERO_SKIP_EN
    , S_SKIP = 3'd5
`endif
  } ctrl_state_e;

  typedef enum logic {
    PH_SQR = 1'b0,
    PH_MUL = 1'b1
  } phase_e;

  typedef enum logic [1:0] {
    ISS_IDLE  = 2'd0,
    ISS_ISSUE = 2'd1,
    ISS_ARM   = 2'd2,
    ISS_WAIT  = 2'd3
  } iss_state_e;

  function automatic opc_t op_for_phase(input phase_e ph);
    return (ph == PH_MUL) ? OPXM : OPXX;
  endfunction

endpackage

// File: rtl/mp_issue.sv
// Start-pulse / stop-guard handshake with mon_prod: one start pulse per go,
// a guard cycle that masks the stale stop level, then wait for stop.
module mp_issue
  import mp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic mp_stop,
  output logic mp_start,
  output logic complete
);

  iss_state_e state_q, state_d;
  logic       start_q, start_d;

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    case (state_q)
      ISS_IDLE: begin
        if (go) begin
          state_d = ISS_ISSUE;
          start_d = 1'b1;
        end
      end
      ISS_ISSUE: state_d = ISS_ARM;
      ISS_ARM:   state_d = ISS_WAIT;
      ISS_WAIT:  if (mp_stop) state_d = ISS_IDLE;
      default:   state_d = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISS_IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  assign mp_start = start_q;
  assign complete = (state_q == ISS_WAIT) && mp_stop;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving mon_prod (OPXX/OPXM/OPX1).
// Optional macro LEADING_ZERO_SKIP_EN skips leading zero exponent bits without issuing ops.
//
// state | meaning
// IDLE  | waiting for start
// SKIP  | walking idx down past leading zeros (LEADING_ZERO_SKIP_EN only)
// NEXT  | choose OPXX/OPXM for the current bit and phase
// FINAL | choose OPX1 to leave the Montgomery domain
// OP    | op in flight (ISSUE/ARM/WAIT handled by mp_issue)
// DONE  | one-cycle done pulse, drop busy
module mod_exp_ctrl
  import mp_pkg::*;
#(
  parameter int EXP_BITS = BITLEN,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [EXP_BITS-1:0] exponent,
  input  logic [IDX_W-1:0]    exp_len,
  input  logic [9:0]          mp_count_in,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      op_cnt,
  output logic                mp_start,
  output logic [OPC_W-1:0]    mp_op_code,
  output logic [9:0]          mp_count,
  input  logic                mp_stop
);

  localparam int BIT_W = $clog2(EXP_BITS);
  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(EXP_BITS);

  ctrl_state_e         state_q, state_d;
  logic [EXP_BITS-1:0] exp_q, exp_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  phase_e              phase_q, phase_d;
  logic                final_q, final_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [IDX_W:0]      op_cnt_q, op_cnt_d;
  opc_t                op_q, op_d;
  logic [9:0]          mp_count_q, mp_count_d;

  logic                go;
  logic                complete;
  logic                cur_bit;
  logic [IDX_W-1:0]    len_c;

  assign cur_bit = exp_q[idx_q[BIT_W-1:0]];
  assign len_c   = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    final_d    = final_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    op_cnt_d   = op_cnt_q;
    op_d       = op_q;
    mp_count_d = mp_count_q;
    go         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d      = exponent;
          mp_count_d = mp_count_in;
          op_cnt_d   = '0;
          busy_d     = 1'b1;
          phase_d    = PH_SQR;
          if (len_c == '0) begin
            state_d = S_FINAL;
          end else begin
            idx_d = len_c - IDX_W'(1);
`ifdef LEADING_ZERO_SKIP_EN
            state_d = S_SKIP;
`else
            state_d = S_NEXT;
`endif
          end
        end
      end
`ifdef LEADING_ZERO_SKIP_EN
      S_SKIP: begin
        if (cur_bit) begin
          phase_d = PH_SQR;
          state_d = S_NEXT;
        end else if (idx_q == '0) begin
          state_d = S_FINAL;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
`endif
      S_NEXT: begin
        op_d     = op_for_phase(phase_q);
        go       = 1'b1;
        op_cnt_d = op_cnt_q + (IDX_W+1)'(1);
        state_d  = S_OP;
      end
      S_FINAL: begin
        op_d     = OPX1;
        final_d  = 1'b1;
        go       = 1'b1;
        op_cnt_d = op_cnt_q + (IDX_W+1)'(1);
        state_d  = S_OP;
      end
      S_OP: begin
        if (complete) begin
          if (final_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (phase_q == PH_SQR && cur_bit) begin
            phase_d = PH_MUL;
            state_d = S_NEXT;
          end else begin
            phase_d = PH_SQR;
            if (idx_q == '0) begin
              state_d = S_FINAL;
            end else begin
              idx_d   = idx_q - IDX_W'(1);
              state_d = S_NEXT;
            end
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        final_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      idx_q      <= '0;
      phase_q    <= PH_SQR;
      final_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_cnt_q   <= '0;
      op_q       <= OPXX;
      mp_count_q <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      final_q    <= final_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      op_cnt_q   <= op_cnt_d;
      op_q       <= op_d;
      mp_count_q <= mp_count_d;
    end
  end

  mp_issue u_issue (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .mp_stop  (mp_stop),
    .mp_start (mp_start),
    .complete (complete)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign op_cnt     = op_cnt_q;
  assign mp_op_code = op_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a mon_prod model (stop latency 6 cycles).
// Expectations follow LEADING_ZERO_SKIP_EN when it is defined.
module tb_mod_exp_ctrl;
  import mp_pkg::*;

  localparam int EXP_BITS = 1024;
  localparam int IDX_W    = 11;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [EXP_BITS-1:0] exponent;
  logic [IDX_W-1:0]    exp_len;
  logic [9:0]          mp_count_in;
  logic                busy;
  logic                done;
  logic [IDX_W:0]      op_cnt;
  logic                mp_start;
  logic [OPC_W-1:0]    mp_op_code;
  logic [9:0]          mp_count;
  logic                mp_stop = 1'b1;

  int n_vec  = 0;
  int n_fail = 0;

  logic [63:0] log_ops;
  int          log_n;
  int          done_cnt;

  logic        late_clear = 1'b0;
  logic        pend = 1'b0;
  int          mcnt = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.EXP_BITS(EXP_BITS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .exponent   (exponent),
    .exp_len    (exp_len),
    .mp_count_in(mp_count_in),
    .busy       (busy),
    .done       (done),
    .op_cnt     (op_cnt),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .mp_stop    (mp_stop)
  );

  // mon_prod model: stop drops after mp_start (one cycle later if late_clear), rises 6 cycles on
  always @(posedge clk) begin
    if (mp_start) begin
      mcnt <= 6;
      pend <= late_clear;
      if (!late_clear) mp_stop <= 1'b0;
    end else begin
      if (pend) begin
        mp_stop <= 1'b0;
        pend    <= 1'b0;
      end
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) mp_stop <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (mp_start) begin
      log_ops = (log_ops << 2) | 64'(mp_op_code);
      log_n   = log_n + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_ops  = '0;
    log_n    = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [EXP_BITS-1:0] e, input logic [IDX_W-1:0] len,
                             input logic [9:0] mpc);
    @(negedge clk);
    exponent    = e;
    exp_len     = len;
    mp_count_in = mpc;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic check_run(input string tag, input logic [63:0] exp_ops, input int exp_n,
                           input logic [9:0] mpc);
    repeat (3) @(negedge clk);
    chk({tag, "_ops"},    log_ops, exp_ops);
    chk({tag, "_nops"},   64'(log_n), 64'(exp_n));
    chk({tag, "_op_cnt"}, 64'(op_cnt), 64'(exp_n));
    chk({tag, "_ndone"},  64'(done_cnt), 64'd1);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_mpcnt"},  64'(mp_count), 64'(mpc));
  endtask

  task automatic run(input string tag, input logic [EXP_BITS-1:0] e, input logic [IDX_W-1:0] len,
                     input logic [9:0] mpc, input logic [63:0] exp_ops, input int exp_n);
    clear_log();
    pulse_start(e, len, mpc);
    wait_done(tag, 20000);
    check_run(tag, exp_ops, exp_n, mpc);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; exponent = '0; exp_len = '0; mp_count_in = '0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_mpst",   64'(mp_start), 64'd0);
    chk("rst_opcode", 64'(mp_op_code), 64'd0);
    chk("rst_mpcnt",  64'(mp_count), 64'd0);
    chk("rst_opcnt",  64'(op_cnt), 64'd0);

    // start together with rst: rst wins
    exp_len = 11'd4; exponent = 1024'hB; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'd0);

    // XX,XM,XX,XX,XM,XX,XM,X1 -> 0,1,0,0,1,0,1,2
    run("b1011", 1024'hB, 11'd4, 10'd17, 64'h1046, 8);
`ifdef LEADING_ZERO_SKIP_EN
    run("b001011", 1024'hB, 11'd6, 10'd33, 64'h1046, 8);
    run("zero_l4", 1024'h0, 11'd4, 10'd2, 64'h2, 1);
    run("clamp", 1024'h1, 11'd2047, 10'd5, 64'h6, 3);
`else
    run("b001011", 1024'hB, 11'd6, 10'd33, 64'h1046, 10);
    run("zero_l4", 1024'h0, 11'd4, 10'd2, 64'h2, 5);
    run("clamp", 1024'h1, 11'd2047, 10'd5, 64'h6, 1026);
`endif
    run("len0", 1024'h5, 11'd0, 10'd9, 64'h2, 1);
    run("hi_ignored", 1024'hF0B, 11'd4, 10'd100, 64'h1046, 8);

    // start during WAIT of the 2nd op is ignored
    clear_log();
    pulse_start(1024'hB, 11'd4, 10'd21);
    k = 0;
    while (log_n < 2 && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    pulse_start(1024'hF, 11'd4, 10'd99);
    wait_done("ign_start", 2000);
    check_run("ign_start", 64'h1046, 8, 10'd21);

    // stop stays high through ARM
    late_clear = 1'b1;
    run("late_clr", 1024'hB, 11'd4, 10'd7, 64'h1046, 8);
    late_clear = 1'b0;

    // reset in WAIT of the 3rd op
    clear_log();
    pulse_start(1024'hB, 11'd4, 10'd3);
    k = 0;
    while (log_n < 3 && k < 200) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_mpst",  64'(mp_start), 64'd0);
    chk("mid_rst_opcnt", 64'(op_cnt), 64'd0);
    repeat (12) @(negedge clk);
    chk("mid_rst_nostart", 64'(log_n), 64'd3);
    run("after_rst", 1024'h1, 11'd1, 10'd11, 64'h6, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
